// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router constants and target-id helper
package noc_pkg;

  localparam int NPORT     = 5;
  localparam int TARG_W    = 3;
  localparam int PAYLOAD_W = 20;

  localparam logic [TARG_W-1:0] PORT1 = 3'd1;
  localparam logic [TARG_W-1:0] PORT2 = 3'd2;
  localparam logic [TARG_W-1:0] PORT3 = 3'd3;
  localparam logic [TARG_W-1:0] PORT4 = 3'd4;
  localparam logic [TARG_W-1:0] PORT5 = 3'd5;

  function automatic logic targ_valid(input logic [TARG_W-1:0] t);
    return (t >= PORT1) && (t <= PORT5);
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// rtl/rr_arbiter5.sv - 5-way round-robin arbiter, combinational one-hot grant
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [NPORT-1:0] o_gnt
);

  logic [3:0] w_sum;
  logic [2:0] w_idx;
  logic       w_hit;

  // Walk from the pointer, wrapping at NPORT; first requester found wins.
  always_comb begin
    o_gnt = '0;
    w_hit = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_sum = 4'(i_ptr) + 4'(k);
      w_idx = (w_sum >= 4'(NPORT)) ? 3'(w_sum - 4'(NPORT)) : 3'(w_sum);
      if (!w_hit && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - credit-aware round-robin switch allocator (SA_PERF_CNT_EN adds grant counters)
module switch_allocator
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [NPORT-1:0]        req_v,
  input  logic [NPORT*TARG_W-1:0] req_targ,
  input  logic [NPORT-1:0]        credit_ret,
  output logic [NPORT-1:0]        cb_ctrl,
  output logic [NPORT-1:0]        gnt,
  output logic [NPORT*3-1:0]      credit_cnt,
  output logic                    err_targ,
  output logic                    err_credit
`ifdef SA_PERF_CNT_EN
  ,
  input  logic [2:0]              cnt_sel,
  output logic [15:0]             cnt_val
`endif
);

  localparam int CW = 3;

  logic [NPORT-1:0] w_arb_req [NPORT];
  logic [NPORT-1:0] w_arb_gnt [NPORT];
  logic [2:0]       w_win     [NPORT];
  logic [NPORT-1:0] w_out_gnt;
  logic [NPORT-1:0] w_gnt_any;
  logic             w_bad_targ;

  logic [2:0]       r_ptr  [NPORT];
  logic [CW-1:0]    r_cred [NPORT];
  logic             r_err_targ;
  logic             r_err_credit;

  // One request column per output; a starved output masks its whole column.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        w_arb_req[o][i] = req_v[i] && (req_targ[TARG_W*i +: TARG_W] == TARG_W'(o + 1))
                          && (r_cred[o] != '0);
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .i_req (w_arb_req[o]),
      .i_ptr (r_ptr[o]),
      .o_gnt (w_arb_gnt[o])
    );
  end

  always_comb begin
    w_gnt_any  = '0;
    w_bad_targ = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      w_out_gnt[o] = |w_arb_gnt[o];
      w_win[o]     = '0;
      for (int i = 0; i < NPORT; i++) begin
        if (w_arb_gnt[o][i]) w_win[o] = 3'(i);
      end
      w_gnt_any = w_gnt_any | w_arb_gnt[o];
    end
    for (int i = 0; i < NPORT; i++) begin
      if (req_v[i] && !targ_valid(req_targ[TARG_W*i +: TARG_W])) w_bad_targ = 1'b1;
    end
  end

  assign gnt        = RST ? '0 : w_gnt_any;
  assign cb_ctrl    = gnt;
  assign err_targ   = r_err_targ;
  assign err_credit = r_err_credit;

  always_comb begin
    for (int o = 0; o < NPORT; o++) credit_cnt[3*o +: 3] = r_cred[o];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int o = 0; o < NPORT; o++) begin
        r_ptr[o]  <= '0;
        r_cred[o] <= CW'(DEPTH);
      end
      r_err_targ   <= 1'b0;
      r_err_credit <= 1'b0;
    end else begin
      if (w_bad_targ) r_err_targ <= 1'b1;
      for (int o = 0; o < NPORT; o++) begin
        if (w_out_gnt[o]) r_ptr[o] <= (w_win[o] == 3'd4) ? 3'd0 : w_win[o] + 3'd1;
        // Simultaneous grant and return cancel out.
        if (w_out_gnt[o] && !credit_ret[o]) begin
          r_cred[o] <= r_cred[o] - CW'(1);
        end else if (credit_ret[o] && !w_out_gnt[o]) begin
          if (r_cred[o] == CW'(DEPTH)) r_err_credit <= 1'b1;
          else                         r_cred[o]    <= r_cred[o] + CW'(1);
        end
      end
    end
  end

`ifdef SA_PERF_CNT_EN
  logic [15:0] r_cnt [NPORT];

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int o = 0; o < NPORT; o++) r_cnt[o] <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (w_out_gnt[o]) r_cnt[o] <= r_cnt[o] + 16'd1;
      end
    end
  end

  assign cnt_val = targ_valid(cnt_sel) ? r_cnt[cnt_sel - 3'd1] : 16'd0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and random checks of switch_allocator against a behavioural model
module tb_switch_allocator;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic [4:0]  req_v;
  logic [14:0] req_targ;
  logic [4:0]  credit_ret;
  logic [4:0]  cb_ctrl;
  logic [4:0]  gnt;
  logic [14:0] credit_cnt;
  logic        err_targ;
  logic        err_credit;
`ifdef SA_PERF_CNT_EN
  logic [2:0]  cnt_sel = 3'd0;
  logic [15:0] cnt_val;
`endif

  always #5 clk = ~clk;

  switch_allocator #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .RST        (RST),
    .req_v      (req_v),
    .req_targ   (req_targ),
    .credit_ret (credit_ret),
    .cb_ctrl    (cb_ctrl),
    .gnt        (gnt),
    .credit_cnt (credit_cnt),
    .err_targ   (err_targ),
    .err_credit (err_credit)
`ifdef SA_PERF_CNT_EN
    ,
    .cnt_sel    (cnt_sel),
    .cnt_val    (cnt_val)
`endif
  );

  int         m_ptr  [5];
  int         m_cred [5];
  bit         m_et;
  bit         m_ec;
  int         vectors;
  int         miscompares;
  logic [4:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_ptr[o]  = 0;
      m_cred[o] = DEPTH;
    end
    m_et = 1'b0;
    m_ec = 1'b0;
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input logic [4:0] v, input logic [14:0] t, input logic [4:0] cr, input logic rst);
    logic [4:0]  eg;
    logic [14:0] ecc;
    int          win [5];
    int          idx;
    int          tg;
    req_v = v; req_targ = t; credit_ret = cr; RST = rst;
    eg  = '0;
    ecc = '0;
    for (int o = 0; o < 5; o++) begin
      win[o] = -1;
      ecc[3*o +: 3] = 3'(m_cred[o]);
      if (!rst && m_cred[o] > 0) begin
        for (int k = 0; k < 5; k++) begin
          idx = (m_ptr[o] + k) % 5;
          tg  = int'(t[3*idx +: 3]);
          if (win[o] < 0 && v[idx] && tg == o + 1) begin
            win[o]  = idx;
            eg[idx] = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    chk("cb_ctrl", 32'(cb_ctrl), 32'(eg));
    chk("gnt", 32'(gnt), 32'(eg));
    chk("credit_cnt", 32'(credit_cnt), 32'(ecc));
    chk("err_targ", 32'(err_targ), 32'(m_et));
    chk("err_credit", 32'(err_credit), 32'(m_ec));
    last_gnt = gnt;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 5; i++) begin
        tg = int'(t[3*i +: 3]);
        if (v[i] && (tg < 1 || tg > 5)) m_et = 1'b1;
      end
      for (int o = 0; o < 5; o++) begin
        if (win[o] >= 0) m_ptr[o] = (win[o] + 1) % 5;
        if (win[o] >= 0 && !cr[o]) m_cred[o] = m_cred[o] - 1;
        else if (cr[o] && win[o] < 0) begin
          if (m_cred[o] == DEPTH) m_ec = 1'b1;
          else                    m_cred[o] = m_cred[o] + 1;
        end
      end
    end
    #1;
  endtask

  logic [4:0]  seq [3];
  logic [14:0] rt;
  int          ngr;

  initial begin
    seq[0] = 5'b00001; seq[1] = 5'b00100; seq[2] = 5'b10000;
    vectors = 0; miscompares = 0;
    RST = 1'b1; req_v = '0; req_targ = '0; credit_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    cycle(5'b0, 15'o0, 5'b0, 1'b1);
    cycle(5'b0, 15'o0, 5'b0, 1'b0);
    chk("idle_cred", 32'(credit_cnt), 32'(15'o44444));

    // inputs 1,3,5 -> output 2 with continuous credit return
    for (int n = 0; n < 6; n++) begin
      cycle(5'b10101, 15'o20202, 5'b00010, 1'b0);
      chk("rr_seq", 32'(last_gnt), 32'(seq[n % 3]));
    end
    chk("o2_cred", 32'(credit_cnt[5:3]), 32'd4);

    // input 1 -> output 4 drains credits
    ngr = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(5'b00001, 15'o00004, 5'b0, 1'b0);
      if (last_gnt[0]) ngr++;
    end
    chk("o4_grants", 32'(ngr), 32'd4);
    chk("o4_cred0", 32'(credit_cnt[11:9]), 32'd0);
    ngr = 0;
    cycle(5'b00001, 15'o00004, 5'b01000, 1'b0);
    if (last_gnt[0]) ngr++;
    for (int n = 0; n < 3; n++) begin
      cycle(5'b00001, 15'o00004, 5'b0, 1'b0);
      if (last_gnt[0]) ngr++;
    end
    chk("o4_regrant", 32'(ngr), 32'd1);

    // reset mid-traffic
    cycle(5'b00001, 15'o00004, 5'b0, 1'b1);
    chk("rst_cred", 32'(credit_cnt), 32'(15'o44444));
    cycle(5'b0, 15'o0, 5'b0, 1'b0);

    // all distinct targets
    cycle(5'b11111, 15'o54321, 5'b0, 1'b0);
    chk("all_gnt", 32'(last_gnt), 32'h1f);
    chk("all_cred", 32'(credit_cnt), 32'(15'o33333));

    // invalid targets on input 2
    cycle(5'b00010, 15'o00000, 5'b0, 1'b0);
    chk("bad0_gnt", 32'(last_gnt), 32'd0);
    chk("err_targ_set", 32'(err_targ), 32'd1);
    cycle(5'b00010, 15'o00070, 5'b0, 1'b0);
    chk("bad7_gnt", 32'(last_gnt), 32'd0);
    cycle(5'b0, 15'o0, 5'b0, 1'b0);
    chk("err_targ_hold", 32'(err_targ), 32'd1);
    cycle(5'b0, 15'o0, 5'b0, 1'b1);
    chk("err_targ_clr", 32'(err_targ), 32'd0);

    // credit overflow and grant+return cancel
    cycle(5'b0, 15'o0, 5'b00001, 1'b0);
    chk("err_credit_set", 32'(err_credit), 32'd1);
    chk("o1_cred_sat", 32'(credit_cnt[2:0]), 32'd4);
    cycle(5'b00001, 15'o00003, 5'b0, 1'b0);
    cycle(5'b00001, 15'o00003, 5'b00100, 1'b0);
    chk("o3_gnt_ret", 32'(last_gnt), 32'd1);
    chk("o3_cred_same", 32'(credit_cnt[8:6]), 32'd3);
    cycle(5'b0, 15'o0, 5'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 15) == 0) rt[3*i +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'(6 + $urandom_range(0, 1));
        else                            rt[3*i +: 3] = 3'($urandom_range(1, 5));
      end
      cycle(5'($urandom), rt, 5'($urandom & $urandom), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
